jk_mod_counter: RTL and testbench

- Synchronous modulo-N up/down counter built as a bank of JK flip-flop cells. Each cell's next state follows the JK characteristic equation.
- Per-bit J/K excitation logic sits directly upstream of the JK storage cells and drives them; the cells produce Q/Q_NOT.
- Used as the next-level sequential stage in the lab designs (BCD counters, dividers).
- Exposes the J/K excitation vectors so benches can check excitation and state together.

---
 rtl/jk_mod_counter.sv | 92 +++++++++
 tb/tb_jk_mod_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a bank of JK flip-flop cells.
// The J/K excitation is computed combinationally from the current state and
// the controls, exported on J_VEC/K_VEC, and is the only path into the state.
module jk_mod_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_NOT,
   output logic [WIDTH-1:0] J_VEC,
   output logic [WIDTH-1:0] K_VEC,
   output logic             TC
);

   // One extra bit so MODULUS == 2**WIDTH stays representable in compares.
   localparam int unsigned   EW      = WIDTH + 1;
   localparam logic [EW-1:0] MOD_EXT = EW'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] load_target;
   logic [WIDTH-1:0] chain_up;
   logic [WIDTH-1:0] chain_down;
   logic             at_max;
   logic             at_zero;
   logic             out_of_range;

   assign at_max       = (q_reg == MAX_VAL);
   assign at_zero      = (q_reg == '0);
   assign out_of_range = ({1'b0, q_reg} >= MOD_EXT);
   assign load_target  = ({1'b0, D} >= MOD_EXT) ? MAX_VAL : D;

   // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) / 0 (down).
   assign chain_up[0]   = 1'b1;
   assign chain_down[0] = 1'b1;
   for (genvar g = 1; g < WIDTH; g++) begin : g_chain
      assign chain_up[g]   = chain_up[g-1] & q_reg[g-1];
      assign chain_down[g] = chain_down[g-1] & ~q_reg[g-1];
   end

   // Per-bit J/K excitation with load > count > hold priority.
   always_comb begin
      J_VEC = '0;
      K_VEC = '0;
      if (LOAD) begin
         J_VEC = load_target;
         K_VEC = ~load_target;
      end else if (EN) begin
         if (UP) begin
            if (out_of_range) begin
               J_VEC = '0;
               K_VEC = '1;
            end else if (at_max) begin
               J_VEC = '0;
               K_VEC = q_reg;
            end else begin
               J_VEC = chain_up;
               K_VEC = chain_up;
            end
         end else begin
            if (out_of_range || at_zero) begin
               J_VEC = MAX_VAL;
               K_VEC = ~MAX_VAL;
            end else begin
               J_VEC = chain_down;
               K_VEC = chain_down;
            end
         end
      end
   end

   assign TC = EN & ~LOAD & ((UP & at_max) | (~UP & at_zero));

   // JK cell bank: Q+ = J & ~Q | ~K & Q on every bit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_reg <= '0;
      end else begin
         q_reg <= (J_VEC & ~q_reg) | (~K_VEC & q_reg);
      end
   end

   assign Q     = q_reg;
   assign Q_NOT = ~q_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: directed sequences followed by random stimulus,
// two instances (modulus 10 and 16) compared against an arithmetic model.
module tb_jk_mod_counter;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic       UP;
   logic       LOAD;
   logic [3:0] D;

   logic [3:0] q10, qn10, j10, k10;
   logic       tc10;
   logic [3:0] q16, qn16, j16, k16;
   logic       tc16;

   int n_vec;
   int n_err;
   int m10;
   int m16;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
      .Q(q10), .Q_NOT(qn10), .J_VEC(j10), .K_VEC(k10), .TC(tc10)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
      .Q(q16), .Q_NOT(qn16), .J_VEC(j16), .K_VEC(k16), .TC(tc16)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: next value by modular arithmetic, excitation from the
   // set/reset or toggle rule that produces that next value.
   function automatic void model(input int q, input int m, input int en, input int up,
                                 input int ld, input int d,
                                 output int nq, output int j, output int k, output int tc);
      nq = q; j = 0; k = 0;
      if (ld != 0) begin
         nq = (d < m) ? d : m - 1;
         j  = nq;
         k  = (~nq) & 15;
      end else if (en != 0) begin
         if (up != 0) begin
            if (q >= m - 1) begin
               nq = 0;
               j  = 0;
               k  = (q >= m) ? 15 : q;
            end else begin
               nq = q + 1;
               j  = q ^ nq;
               k  = j;
            end
         end else begin
            if (q == 0 || q >= m) begin
               nq = m - 1;
               j  = nq;
               k  = (~nq) & 15;
            end else begin
               nq = q - 1;
               j  = q ^ nq;
               k  = j;
            end
         end
      end
      tc = (en != 0 && ld == 0 && ((up != 0 && q == m - 1) || (up == 0 && q == 0))) ? 1 : 0;
   endfunction

   // Apply one cycle of controls: check excitation/TC, clock, check state.
   task automatic step(input logic en, input logic up, input logic ld, input logic [3:0] d);
      int n10, jj10, kk10, t10;
      int n16, jj16, kk16, t16;
      EN = en; UP = up; LOAD = ld; D = d;
      #2;
      model(m10, 10, int'(en), int'(up), int'(ld), int'(d), n10, jj10, kk10, t10);
      model(m16, 16, int'(en), int'(up), int'(ld), int'(d), n16, jj16, kk16, t16);
      check("j10", int'(j10), jj10);
      check("k10", int'(k10), kk10);
      check("tc10", int'(tc10), t10);
      check("j16", int'(j16), jj16);
      check("k16", int'(k16), kk16);
      check("tc16", int'(tc16), t16);
      @(posedge CLK);
      if (RST_N) begin
         m10 = n10;
         m16 = n16;
      end else begin
         m10 = 0;
         m16 = 0;
      end
      #1;
      check("q10", int'(q10), m10);
      check("qn10", int'(qn10), (~m10) & 15);
      check("q16", int'(q16), m16);
      check("qn16", int'(qn16), (~m16) & 15);
   endtask

   initial begin
      n_vec = 0; n_err = 0; m10 = 0; m16 = 0;
      RST_N = 1'b0; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; D = 4'd0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_q10", int'(q10), 0);
      check("rst_qn10", int'(qn10), 15);
      check("rst_q16", int'(q16), 0);
      RST_N = 1'b1;

      // Up count 12 edges: 1..9,0,1,2
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
      // Down 4 edges from 2: 1,0,9,8
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
      // Load, clamp, hold
      step(1'b1, 1'b1, 1'b1, 4'd6);
      step(1'b0, 1'b1, 1'b1, 4'd13);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
      // Load beats count at Q=9
      step(1'b1, 1'b1, 1'b1, 4'd3);
      step(1'b0, 1'b1, 1'b1, 4'd5);
      // Direction change every edge: 6,5,6,5
      for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);

      // Asynchronous reset mid-cycle with Q=7
      step(1'b0, 1'b1, 1'b1, 4'd7);
      #3;
      RST_N = 1'b0;
      #1;
      check("async_q10", int'(q10), 0);
      check("async_qn10", int'(qn10), 15);
      check("async_q16", int'(q16), 0);
      m10 = 0; m16 = 0;
      step(1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      RST_N = 1'b1;

      // Full-range roll-over on the modulus-16 instance
      step(1'b0, 1'b1, 1'b1, 4'd15);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
